// File: rtl/mmio_console_ctrl.sv
// Console/halt MMIO controller: decodes console and halt stores from the core,
// buffers console bytes in a small FIFO drained on a valid/ready byte stream,
// and sequences an orderly halt (stall core, drain FIFO, then assert halted).
module mmio_console_ctrl #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h8000_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h8000_0004,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wd,
  output logic        dmem_we,
  output logic        stall,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [7:0]  exit_code
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic con_hit;
  logic halt_hit;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drain_done;

  // Upper store-data bits are irrelevant to console and halt stores
  logic unused_wd_bits;
  assign unused_wd_bits = ^mem_wd[31:8];

  // Address decode, back-pressure and FIFO handshake
  always_comb begin
    con_hit    = mem_we && (mem_addr == CONSOLE_ADDR);
    halt_hit   = mem_we && (mem_addr == HALT_ADDR);
    full       = (count == CNT_W'(FIFO_DEPTH));
    empty      = (count == CNT_W'(0));
    stall      = 1'b1;
    if (state == RUN) begin
      stall = con_hit && full;
    end
    push       = con_hit && !stall && (state == RUN);
    tx_valid   = !empty;
    tx_data    = fifo_mem[rd_ptr];
    pop        = tx_valid && tx_ready;
    dmem_we    = mem_we && !con_hit && !halt_hit && !stall;
    drain_done = empty || ((count == CNT_W'(1)) && pop);
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_wd[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Halt sequencing with registered halted/exit_code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      halted    <= 1'b0;
      exit_code <= 8'h00;
    end else begin
      case (state)
        RUN: begin
          if (halt_hit) begin
            exit_code <= mem_wd[7:0];
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            halted <= 1'b1;
            state  <= HALTED;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_console_ctrl.sv
// Directed self-checking bench for mmio_console_ctrl.
module tb_mmio_console_ctrl;

  localparam logic [31:0] CON  = 32'h8000_0000;
  localparam logic [31:0] HALT = 32'h8000_0004;
  localparam logic [31:0] MEM  = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        dmem_we;
  logic        stall;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halted;
  logic [7:0]  exit_code;

  int checks = 0;
  int errors = 0;

  mmio_console_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .dmem_we   (dmem_we),
    .stall     (stall),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .halted    (halted),
    .exit_code (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rdy);
    mem_we   = we;
    mem_addr = addr;
    mem_wd   = wd;
    tx_ready = rdy;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, CON, 32'hDEAD_BE5A, 1'b1);

    // Reset with a console store pending, then a halt store pending
    tick(); tick();
    mid();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_txvalid", 32'(tx_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_exit", 32'(exit_code), 32'h00);
    chk("rst_dmem_con", 32'(dmem_we), 32'd0);
    drive(1'b1, HALT, 32'h0000_0099, 1'b0);
    tick(); tick();
    mid();
    chk("rst_exit_halt", 32'(exit_code), 32'h00);
    chk("rst_halted2", 32'(halted), 32'd0);

    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    reset = 1'b1;
    tick();

    // Console ordering with ready held high
    drive(1'b1, CON, 32'hFFFF_FF48, 1'b1);
    mid();
    chk("con0_txvalid", 32'(tx_valid), 32'd0);
    chk("con0_dmem", 32'(dmem_we), 32'd0);
    chk("con0_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b1, CON, 32'h0000_0069, 1'b1);
    mid();
    chk("con1_txvalid", 32'(tx_valid), 32'd1);
    chk("con1_data", 32'(tx_data), 32'h48);
    chk("con1_dmem", 32'(dmem_we), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    mid();
    chk("con2_txvalid", 32'(tx_valid), 32'd1);
    chk("con2_data", 32'(tx_data), 32'h69);
    chk("con2_dmem", 32'(dmem_we), 32'd0);
    tick();
    mid();
    chk("con3_txvalid", 32'(tx_valid), 32'd0);
    tick();

    // Fill the FIFO with 0x00..0x07 while the consumer is not ready
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, CON, 32'(i), 1'b0);
      mid();
      chk($sformatf("fill%0d_stall", i), 32'(stall), 32'd0);
      tick();
    end
    // Ninth store must be back-pressured
    drive(1'b1, CON, 32'h0000_0008, 1'b0);
    mid();
    chk("full_stall", 32'(stall), 32'd1);
    chk("full_dmem", 32'(dmem_we), 32'd0);
    chk("full_head", 32'(tx_data), 32'h00);
    tick();
    // Single-cycle ready pulse pops 0x00; store still held
    drive(1'b1, CON, 32'h0000_0008, 1'b1);
    mid();
    chk("pulse_stall", 32'(stall), 32'd1);
    chk("pulse_head", 32'(tx_data), 32'h00);
    tick();
    drive(1'b1, CON, 32'h0000_0008, 1'b0);
    mid();
    chk("after_pop_stall", 32'(stall), 32'd0);
    chk("after_pop_head", 32'(tx_data), 32'h01);
    tick();
    // Drain remaining bytes in order
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      mid();
      chk($sformatf("drain%0d_valid", j), 32'(tx_valid), 32'd1);
      chk($sformatf("drain%0d_data", j), 32'(tx_data), 32'(j));
      tick();
    end
    mid();
    chk("drain_empty", 32'(tx_valid), 32'd0);
    tick();

    // Pass-through store with one byte queued
    drive(1'b1, CON, 32'h0000_0077, 1'b0);
    tick();
    drive(1'b1, MEM, 32'h1234_5678, 1'b0);
    mid();
    chk("pass_dmem", 32'(dmem_we), 32'd1);
    chk("pass_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    mid();
    chk("pass_valid", 32'(tx_valid), 32'd1);
    chk("pass_data", 32'(tx_data), 32'h77);
    tick();
    mid();
    chk("pass_empty", 32'(tx_valid), 32'd0);
    tick();

    // Halt with three bytes of backlog
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, CON, 32'h31 + 32'(k), 1'b0);
      tick();
    end
    drive(1'b1, HALT, 32'hABCD_EF2A, 1'b0);
    mid();
    chk("h_stall", 32'(stall), 32'd0);
    chk("h_dmem", 32'(dmem_we), 32'd0);
    chk("h_halted", 32'(halted), 32'd0);
    tick();
    drive(1'b1, HALT, 32'h0000_0055, 1'b1);
    mid();
    chk("h1_stall", 32'(stall), 32'd1);
    chk("h1_exit", 32'(exit_code), 32'h2A);
    chk("h1_data", 32'(tx_data), 32'h31);
    chk("h1_halted", 32'(halted), 32'd0);
    chk("h1_dmem", 32'(dmem_we), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    mid();
    chk("h2_data", 32'(tx_data), 32'h32);
    chk("h2_halted", 32'(halted), 32'd0);
    tick();
    mid();
    chk("h3_data", 32'(tx_data), 32'h33);
    chk("h3_halted", 32'(halted), 32'd0);
    chk("h3_stall", 32'(stall), 32'd1);
    tick();
    drive(1'b1, MEM, 32'h0000_0001, 1'b1);
    mid();
    chk("h4_halted", 32'(halted), 32'd1);
    chk("h4_stall", 32'(stall), 32'd1);
    chk("h4_valid", 32'(tx_valid), 32'd0);
    chk("h4_dmem", 32'(dmem_we), 32'd0);
    tick();
    drive(1'b1, HALT, 32'h0000_0055, 1'b1);
    tick();
    mid();
    chk("h5_exit", 32'(exit_code), 32'h2A);
    chk("h5_halted", 32'(halted), 32'd1);

    // Leave HALTED through reset
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rh_halted", 32'(halted), 32'd0);
    chk("rh_exit", 32'(exit_code), 32'h00);
    chk("rh_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Reset mid-DRAIN discards queued bytes
    drive(1'b1, CON, 32'h10, 1'b0);
    tick();
    drive(1'b1, CON, 32'h11, 1'b0);
    tick();
    drive(1'b1, HALT, 32'h07, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    mid();
    chk("rd_stall", 32'(stall), 32'd1);
    chk("rd_exit", 32'(exit_code), 32'h07);
    tick();
    reset = 1'b0;
    #1;
    chk("rd_rst_stall", 32'(stall), 32'd0);
    chk("rd_rst_valid", 32'(tx_valid), 32'd0);
    chk("rd_rst_halted", 32'(halted), 32'd0);
    chk("rd_rst_exit", 32'(exit_code), 32'h00);
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, CON, 32'h41, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    mid();
    chk("rd_post_valid", 32'(tx_valid), 32'd1);
    chk("rd_post_data", 32'(tx_data), 32'h41);
    tick();
    mid();
    chk("rd_post_empty", 32'(tx_valid), 32'd0);
    chk("rd_post_stall", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
